div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
Iterative radix-2 restoring divider, 32 iterations, one quotient bit per cycle. It serves the EX-stage ALU for DIV/DIVU. It consumes start_div and signed_div and the ALU operands, and returns a 64-bit {remainder, quotient} result plus ready_o, which the ALU uses to release its stall and to steer the result into HI/LO. It also exports its FSM state so the ALU and hazard logic can observe divider occupancy.

Parameters:
DATA_W, 32, operand width; the iteration count equals DATA_W; the counter is clog2(DATA_W)+1 bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; synchronous, active-high.
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only at start acceptance.
opdata1_i  input  DATA_W  dividend; sampled only at start acceptance.
opdata2_i  input  DATA_W  divisor; sampled only at start acceptance.
start_i  input  1  request; held high by the ALU until ready_o is seen.
annul_i  input  1  abort the in-flight division (e.g. exception flush).
result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; maps to HI/LO.
ready_o  output  1  result valid.
state  output  2  FSM state: FREE=00, BYZERO=01, ON=10, END=11.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=FREE, ready_o=0, result_o=0, counter=0, working regs=0.
  - Reset mid-operation has the same effect and wins over every other input.
- FREE:
  - Ignored if start_i=0 or annul_i=1.
  - Otherwise, if divisor==0: go to BYZERO.
  - Otherwise, at the accepting edge E0:
    - latch the sign flags (dividend sign, and dividend sign XOR divisor sign);
    - if signed, load the two's-complement magnitudes of both operands, else the raw values;
    - clear the 65-bit partial-remainder/dividend shift register and load the dividend into its low half;
    - counter=0; go to ON.
- ON, each edge:
  - Shift {rem, dvd} left by 1 and trial-subtract the divisor from rem.
  - If no borrow, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - counter++.
  - On the 32nd iteration edge (E32):
    - quotient = negate if the quotient-sign flag is set;
    - remainder = negate if the dividend was negative (signed only);
    - register result_o, set ready_o=1, go to END.
  - annul_i=1 at any ON edge: go to FREE, ready_o=0, result_o=0; no result is produced.
  - start_i toggling while ON is ignored.
- BYZERO: next edge goes to END with result_o=0 and ready_o=1. MIPS leaves the result undefined; zero is the decided value.
- END:
  - While start_i=1: hold result_o and ready_o=1.
  - When start_i=0: go to FREE; ready_o=0 and result_o=0 on that edge.
  - annul_i in END is ignored.
- Latency:
  - Nonzero divisor: ready_o high after edge E0+32.
  - Zero divisor: ready_o high after E0+1.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This is the natural wrap, with no exception.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- defines.vh holds:
  - the state encodings DivFree / DivByZero / DivOn / DivEnd;
  - DivStart / DivStop;
  - DivResultReady / DivResultNotReady;
  - the ALUOP_DIV / ALUOP_DIVU codes already there.
- No sub-module. The iteration step (shift, subtract, select) and the sign fixups stay inline as combinational wires feeding the FSM registers.

Test Plan:
1. Unsigned 100 / 7, signed_div_i=0, start held → ready_o first high 32 edges after acceptance; result_o = {0x00000002, 0x0000000E}; state sequence FREE→ON→END.
2. Signed 0xFFFFFFF9 (-7) / 0x00000002 → result_o = {0xFFFFFFFF, 0xFFFFFFFD}; a second case, 7 / -2, → {0x00000001, 0xFFFFFFFD}.
3. Divide by zero, 5 / 0 → state BYZERO for one cycle then END; ready_o high one edge after acceptance; result_o=0. Dropping start_i then returns state to FREE and clears ready_o.
4. annul_i pulsed during the 10th iteration → state FREE next cycle, ready_o never asserts. A following unsigned 0xFFFFFFFF / 0x10 → {0x0000000F, 0x0FFFFFFF}.
5. Signed 0x80000000 / 0xFFFFFFFF → result_o = {0x00000000, 0x80000000}, with no hang or X.
6. rst asserted for one edge at iteration 5 → after that edge state=00, ready_o=0, result_o=0. A new 9 / 3 then completes normally with {0, 3}.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and helpers for the iterative radix-2 restoring divider.
package div_iter_pkg;

   localparam int unsigned DIV_DATA_W = 32;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   // Two's-complement negate when neg is set, pass-through otherwise.
   function automatic logic [DIV_DATA_W-1:0] cond_neg(input logic [DIV_DATA_W-1:0] v,
                                                      input logic neg);
      return neg ? DIV_DATA_W'(~v + DIV_DATA_W'(1)) : v;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// registered {remainder, quotient} result with ready handshake.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic [1:0]            state
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   div_state_e          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rem_q;
   logic [DATA_W-1:0]   dvd_q;
   logic [DATA_W-1:0]   divisor_q;
   logic                neg_quo_q;
   logic                neg_rem_q;
   logic [2*DATA_W-1:0] result_q;
   logic                ready_q;

   // One iteration: shift {rem, dvd} left, trial-subtract, restore on borrow.
   logic [DATA_W:0]     rem_sh;
   logic                fits;
   logic [DATA_W-1:0]   rem_next;
   logic [DATA_W-1:0]   dvd_next;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;
   logic                last_iter;

   assign rem_sh    = {rem_q, dvd_q[DATA_W-1]};
   assign fits      = (rem_sh >= {1'b0, divisor_q});
   assign rem_next  = fits ? DATA_W'(rem_sh - {1'b0, divisor_q}) : rem_sh[DATA_W-1:0];
   assign dvd_next  = {dvd_q[DATA_W-2:0], fits};
   assign quo_fix   = cond_neg(dvd_next, neg_quo_q);
   assign rem_fix   = cond_neg(rem_next, neg_rem_q);
   assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DIV_FREE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         divisor_q <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= DIV_RESULT_NOT_READY;
      end else begin
         unique case (state_q)
            DIV_FREE: begin
               if (start_i == DIV_START && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state_q <= DIV_BYZERO;
                  end else begin
                     neg_rem_q <= signed_div_i & opdata1_i[DATA_W-1];
                     neg_quo_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                     dvd_q     <= cond_neg(opdata1_i, signed_div_i & opdata1_i[DATA_W-1]);
                     divisor_q <= cond_neg(opdata2_i, signed_div_i & opdata2_i[DATA_W-1]);
                     rem_q     <= '0;
                     cnt_q     <= '0;
                     state_q   <= DIV_ON;
                  end
               end
            end
            DIV_BYZERO: begin
               result_q <= '0;
               ready_q  <= DIV_RESULT_READY;
               state_q  <= DIV_END;
            end
            DIV_ON: begin
               if (annul_i) begin
                  result_q <= '0;
                  ready_q  <= DIV_RESULT_NOT_READY;
                  state_q  <= DIV_FREE;
               end else begin
                  rem_q <= rem_next;
                  dvd_q <= dvd_next;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_iter) begin
                     result_q <= {rem_fix, quo_fix};
                     ready_q  <= DIV_RESULT_READY;
                     state_q  <= DIV_END;
                  end
               end
            end
            DIV_END: begin
               if (start_i == DIV_STOP) begin
                  result_q <= '0;
                  ready_q  <= DIV_RESULT_NOT_READY;
                  state_q  <= DIV_FREE;
               end
            end
            default: state_q <= DIV_FREE;
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign state    = state_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter with hand-computed quotients/remainders.
module tb_div_iter;

   logic        clk;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic [1:0]  state_w;

   int checks   = 0;
   int failures = 0;

   div_iter dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready),
      .state        (state_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Full handshake: accept, wait for ready, hold, release.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
      @(posedge clk); #1;
      check({tag, "_accept_state"}, 64'(state_w), (b == 32'd0) ? 64'd1 : 64'd2);
      lat = 0;
      while (!ready && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_result"}, result, exp);
      check({tag, "_end_state"}, 64'(state_w), 64'd3);
      @(negedge clk);
      op1 = $urandom; op2 = $urandom; signed_div = ~signed_div;
      @(posedge clk); #1;
      check({tag, "_hold"}, {result[62:0], ready}, {exp[62:0], 1'b1});
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check({tag, "_release"}, {62'(result), state_w}, 64'd0);
      check({tag, "_release_ready"}, 64'(ready), 64'd0);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 64'(state_w), 64'd0);
      check("reset_ready", 64'(ready), 64'd0);
      check("reset_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 32);
      run_div("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32);
      run_div("sdiv_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 32);
      run_div("div_by_zero", 1'b0, 32'd5, 32'd0, 64'd0, 1);

      // Annul during the 10th iteration
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      check("annul_state", 64'(state_w), 64'd0);
      check("annul_result", result, 64'd0);
      @(negedge clk);
      annul = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready) seen = 1'b1;
      end
      check("annul_no_ready", 64'(seen), 64'd0);
      run_div("udiv_ffff_10", 1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF}, 32);

      run_div("sdiv_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 32);

      // Reset mid-operation at iteration 5
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      check("midrst_state", 64'(state_w), 64'd0);
      check("midrst_ready", 64'(ready), 64'd0);
      check("midrst_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_div("udiv_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
